// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-RAM port controller.
// Size encodings, FSM state enum, default RAM width, misalign helper.
package mem_ctrl_pkg;

    localparam int RAM_AW_DEF = 10;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_MERGE,
        ST_RESP
    } state_t;

    // Size 11 behaves as a word, so bit 1 alone marks word accesses.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return ((size == SIZE_H) && off[0]) ||
               (size[1] && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store merge and load extract/extend.
// Ports: i_size, i_off, i_uns, i_old, i_wdata -> o_merged, o_load.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_uns,
    input  logic [31:0] i_old,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [7:0]  w_b;
    logic [15:0] w_h;

    always_comb begin
        w_b      = i_old[{i_off, 3'b000} +: 8];
        w_h      = i_old[{i_off[1], 4'b0000} +: 16];
        o_merged = i_old;
        o_load   = i_old;
        unique case (1'b1)
            (i_size == SIZE_B): begin
                o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
                o_load = i_uns ? {24'd0, w_b}
                               : {{24{w_b[7]}}, w_b};
            end
            (i_size == SIZE_H): begin
                // Half lanes ignore i_off[0].
                o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata;
                o_load = i_uns ? {16'd0, w_h}
                               : {{16{w_h[15]}}, w_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Shares one word-wide RAM between fetch and load/store ports.
// Ports: IF_*, LS_* requesters, RAM_* pins. Macro: MEM_CTRL_MISALIGN_TRAP_EN.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IF_REQ,
    input  logic [31:0]       IF_ADDR,
    output logic              IF_ACK,
    output logic [31:0]       IF_RDATA,
    input  logic              LS_REQ,
    input  logic              LS_WE,
    input  logic [1:0]        LS_SIZE,
    input  logic              LS_UNSIGNED,
    input  logic [31:0]       LS_ADDR,
    input  logic [31:0]       LS_WDATA,
    output logic              LS_ACK,
    output logic [31:0]       LS_RDATA,
    output logic              LS_ERR,
    output logic [RAM_AW-1:0] RAM_ADDRESS,
    output logic [31:0]       RAM_DATA_IN,
    output logic              RAM_WRITE_ENABLE,
    input  logic [31:0]       RAM_DATA_OUT
);

    state_t      r_state;
    logic        r_last_ls;
    logic        r_sel_ls;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;

    logic        w_grant_ls;
    logic        w_grant_if;
    logic [31:0] w_merged;
    logic [31:0] w_load;
    logic        w_unused;

    // On contention the side not granted last wins.
    assign w_grant_ls = LS_REQ && (!IF_REQ || !r_last_ls);
    assign w_grant_if = IF_REQ && !w_grant_ls;

    assign w_unused = ^{IF_ADDR[31:RAM_AW+2], IF_ADDR[1:0],
                        LS_ADDR[31:RAM_AW+2]};

    mem_lane_align u_align (
        .i_size   (r_size),
        .i_off    (r_off),
        .i_uns    (r_uns),
        .i_old    (RAM_DATA_OUT),
        .i_wdata  (r_wdata),
        .o_merged (w_merged),
        .o_load   (w_load)
    );

`ifndef MEM_CTRL_MISALIGN_TRAP_EN
    assign LS_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state          <= ST_IDLE;
            r_last_ls        <= 1'b0;
            r_sel_ls         <= 1'b0;
            r_we             <= 1'b0;
            r_size           <= SIZE_W;
            r_uns            <= 1'b0;
            r_off            <= 2'b00;
            r_wdata          <= 16'd0;
            IF_ACK           <= 1'b0;
            IF_RDATA         <= 32'd0;
            LS_ACK           <= 1'b0;
            LS_RDATA         <= 32'd0;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
            LS_ERR           <= 1'b0;
`endif
            RAM_ADDRESS      <= '0;
            RAM_DATA_IN      <= 32'd0;
            RAM_WRITE_ENABLE <= 1'b0;
        end else begin
            IF_ACK           <= 1'b0;
            LS_ACK           <= 1'b0;
            RAM_WRITE_ENABLE <= 1'b0;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
            LS_ERR           <= 1'b0;
`endif
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant_ls) begin
                        r_sel_ls  <= 1'b1;
                        r_last_ls <= 1'b1;
                        r_we      <= LS_WE;
                        r_size    <= LS_SIZE;
                        r_uns     <= LS_UNSIGNED;
                        r_off     <= LS_ADDR[1:0];
                        r_wdata   <= LS_WDATA[15:0];
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
                        if (misaligned(LS_SIZE, LS_ADDR[1:0])) begin
                            LS_ACK   <= 1'b1;
                            LS_ERR   <= 1'b1;
                            LS_RDATA <= 32'd0;
                            r_state  <= ST_RESP;
                        end else
`endif
                        begin
                            RAM_ADDRESS <= LS_ADDR[RAM_AW+1:2];
                            RAM_DATA_IN <= LS_WDATA;
                            // Word stores write during ACCESS.
                            RAM_WRITE_ENABLE <= LS_WE && LS_SIZE[1];
                            r_state     <= ST_ACCESS;
                        end
                    end else if (w_grant_if) begin
                        r_sel_ls    <= 1'b0;
                        r_last_ls   <= 1'b0;
                        r_we        <= 1'b0;
                        r_size      <= SIZE_W;
                        r_uns       <= 1'b0;
                        r_off       <= 2'b00;
                        RAM_ADDRESS <= IF_ADDR[RAM_AW+1:2];
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_we && !r_size[1]) begin
                        RAM_DATA_IN      <= w_merged;
                        RAM_WRITE_ENABLE <= 1'b1;
                        r_state          <= ST_MERGE;
                    end else begin
                        if (r_sel_ls) begin
                            LS_ACK   <= 1'b1;
                            LS_RDATA <= r_we ? 32'd0 : w_load;
                        end else begin
                            IF_ACK   <= 1'b1;
                            IF_RDATA <= RAM_DATA_OUT;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_MERGE: begin
                    LS_ACK   <= 1'b1;
                    LS_RDATA <= 32'd0;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl with a byte-level reference model.
// Honours MEM_CTRL_MISALIGN_TRAP_EN when defined.
module tb_mem_port_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IF_REQ = 1'b0;
    logic [31:0] IF_ADDR = 32'd0;
    logic        IF_ACK;
    logic [31:0] IF_RDATA;
    logic        LS_REQ = 1'b0;
    logic        LS_WE = 1'b0;
    logic [1:0]  LS_SIZE = 2'b10;
    logic        LS_UNSIGNED = 1'b0;
    logic [31:0] LS_ADDR = 32'd0;
    logic [31:0] LS_WDATA = 32'd0;
    logic        LS_ACK;
    logic [31:0] LS_RDATA;
    logic        LS_ERR;
    logic [9:0]  RAM_ADDRESS;
    logic [31:0] RAM_DATA_IN;
    logic        RAM_WRITE_ENABLE;
    logic [31:0] RAM_DATA_OUT;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [1024];
    logic [31:0] init_val [1024];
    logic        ram_load = 1'b1;
    logic [7:0]  mb [4096];

    mem_port_ctrl #(.RAM_AW(10)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR),
        .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
        .LS_REQ(LS_REQ), .LS_WE(LS_WE), .LS_SIZE(LS_SIZE),
        .LS_UNSIGNED(LS_UNSIGNED), .LS_ADDR(LS_ADDR),
        .LS_WDATA(LS_WDATA), .LS_ACK(LS_ACK),
        .LS_RDATA(LS_RDATA), .LS_ERR(LS_ERR),
        .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATA_IN(RAM_DATA_IN),
        .RAM_WRITE_ENABLE(RAM_WRITE_ENABLE),
        .RAM_DATA_OUT(RAM_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    assign RAM_DATA_OUT = ram[RAM_ADDRESS];

    always @(posedge CLK) begin
        if (ram_load) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_val[i];
        end else if (RAM_WRITE_ENABLE) begin
            ram[RAM_ADDRESS] <= RAM_DATA_IN;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int w);
        int b;
        b = (w % 1024) * 4;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    function automatic logic is_mis(input logic [1:0] sz,
                                    input logic [31:0] a);
        int lo;
        lo = int'(a % 4);
        if (sz == 2'b01) return (lo % 2) != 0;
        if (sz >= 2'b10) return lo != 0;
        return 1'b0;
    endfunction

    function automatic logic trap_on();
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference load: gather bytes, then extend arithmetically.
    function automatic logic [31:0] mload(input logic [1:0] sz,
                                          input logic uns,
                                          input logic [31:0] a);
        int ba;
        longint v;
        ba = int'(a % 4096);
        if (sz == 2'b00) begin
            v = mb[ba];
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'b01) begin
            ba = ba - (ba % 2);
            v = mb[ba] + 256 * mb[ba+1];
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            ba = ba - (ba % 4);
            v = mb[ba] + 256 * mb[ba+1] + 65536 * mb[ba+2]
                + 16777216 * longint'(mb[ba+3]);
        end
        return v[31:0];
    endfunction

    task automatic mstore(input logic [1:0] sz,
                          input logic [31:0] a,
                          input logic [31:0] wd);
        int ba;
        int n;
        logic [31:0] d;
        d = wd;
        ba = int'(a % 4096);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ba = ba - (ba % n);
        for (int k = 0; k < n; k++) begin
            mb[ba+k] = d[7:0];
            d = d >> 8;
        end
    endtask

    logic [31:0] last_rd;

    task automatic ls_op(input string tag,
                         input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd);
        int cyc;
        int lat;
        logic mis;
        logic [31:0] erd;
        logic eerr;
        mis = trap_on() && is_mis(sz, a);
        lat = mis ? 1 : (we && sz < 2'b10) ? 3 : 2;
        eerr = mis;
        erd = (mis || we) ? 32'd0 : mload(sz, uns, a);
        @(posedge CLK); #1;
        LS_REQ = 1'b1; LS_WE = we; LS_SIZE = sz;
        LS_UNSIGNED = uns; LS_ADDR = a; LS_WDATA = wd;
        cyc = 0;
        do begin
            @(posedge CLK); #1;
            cyc++;
        end while (!LS_ACK && cyc < 20);
        last_rd = LS_RDATA;
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        chk({tag, " rdata"}, LS_RDATA, erd);
        chk({tag, " err"}, {31'd0, LS_ERR}, {31'd0, eerr});
        LS_REQ = 1'b0;
        if (we && !mis) mstore(sz, a, wd);
        chk({tag, " ram"}, ram[a[11:2]], mword(int'(a[11:2])));
    endtask

    task automatic if_op(input string tag, input logic [31:0] a);
        int cyc;
        @(posedge CLK); #1;
        IF_REQ = 1'b1; IF_ADDR = a;
        cyc = 0;
        do begin
            @(posedge CLK); #1;
            cyc++;
        end while (!IF_ACK && cyc < 20);
        chk({tag, " latency"}, 32'(cyc), 32'd2);
        chk({tag, " rdata"}, IF_RDATA, mword(int'(a[11:2])));
        IF_REQ = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " acks"}, {29'd0, IF_ACK, LS_ACK, LS_ERR}, 32'd0);
        chk({tag, " if_rdata"}, IF_RDATA, 32'd0);
        chk({tag, " ls_rdata"}, LS_RDATA, 32'd0);
        chk({tag, " ram_addr"}, {22'd0, RAM_ADDRESS}, 32'd0);
        chk({tag, " ram_din"}, RAM_DATA_IN, 32'd0);
        chk({tag, " ram_we"}, {31'd0, RAM_WRITE_ENABLE}, 32'd0);
    endtask

    initial begin
        int acks;
        int cyc;
        int who [4];
        int when [4];
        logic [31:0] dat [4];
        logic [31:0] a;
        logic [1:0] sz;

        for (int i = 0; i < 1024; i++) begin
            init_val[i] = $urandom;
            for (int k = 0; k < 4; k++)
                mb[4*i+k] = init_val[i][8*k +: 8];
        end
        #1;
        chk_reset_outs("reset");
        @(posedge CLK); #1;
        ram_load = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;

        ls_op("sw10", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
        chk("sw10 word4", ram[4], 32'hDEADBEEF);
        ls_op("lw10", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        chk("lw10 const", last_rd, 32'hDEADBEEF);

        ls_op("sw_init", 1'b1, 2'b10, 1'b0, 32'h010, 32'h11223344);
        ls_op("sb13", 1'b1, 2'b00, 1'b0, 32'h013, 32'h000000AA);
        chk("sb13 word4", ram[4], 32'hAA223344);
        ls_op("lb13", 1'b0, 2'b00, 1'b0, 32'h013, 32'h0);
        chk("lb13 const", last_rd, 32'hFFFFFFAA);
        ls_op("lbu13", 1'b0, 2'b00, 1'b1, 32'h013, 32'h0);
        chk("lbu13 const", last_rd, 32'h000000AA);
        ls_op("sh12", 1'b1, 2'b01, 1'b0, 32'h012, 32'h00005566);
        chk("sh12 word4", ram[4], 32'h55663344);

        ls_op("lw11", 1'b0, 2'b10, 1'b0, 32'h011, 32'h0);
        chk("lw11 const", last_rd,
            trap_on() ? 32'd0 : 32'h55663344);
        ls_op("lh13", 1'b0, 2'b01, 1'b0, 32'h013, 32'h0);

        if_op("if_wrap", 32'h00001010);

        // Both requesters held from reset.
        @(posedge CLK); #1;
        RST_N = 1'b0;
        IF_REQ = 1'b1; IF_ADDR = 32'h020;
        LS_REQ = 1'b1; LS_WE = 1'b0; LS_SIZE = 2'b10;
        LS_UNSIGNED = 1'b0; LS_ADDR = 32'h024;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        acks = 0;
        cyc = 0;
        while (acks < 4 && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
            if (IF_ACK || LS_ACK) begin
                who[acks] = LS_ACK ? 1 : 0;
                when[acks] = cyc;
                dat[acks] = LS_ACK ? LS_RDATA : IF_RDATA;
                if (IF_ACK && LS_ACK) who[acks] = 2;
                acks++;
            end
        end
        IF_REQ = 1'b0;
        LS_REQ = 1'b0;
        chk("cont acks", 32'(acks), 32'd4);
        for (int k = 0; k < acks; k++) begin
            chk("cont who", 32'(who[k]), 32'((k + 1) % 2));
            chk("cont when", 32'(when[k]), 32'(2 + 3 * k));
            chk("cont data", dat[k],
                mword((k % 2 == 0) ? 9 : 8));
        end

        // Reset during ACCESS of a byte store.
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        LS_REQ = 1'b1; LS_WE = 1'b1; LS_SIZE = 2'b00;
        LS_ADDR = 32'h013; LS_WDATA = 32'h00000077;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        LS_REQ = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(posedge CLK); #1;
        RST_N = 1'b1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            if (LS_ACK || IF_ACK) acks++;
        end
        chk("midrst noack", 32'(acks), 32'd0);
        chk("midrst word4", ram[4], mword(4));
        ls_op("midrst lw", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0);

        for (int n = 0; n < 40; n++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                if_op("rnd if", a);
            else
                ls_op("rnd ls", 1'($urandom), sz, 1'($urandom),
                      a, $urandom);
        end
        for (int w = 0; w < 16; w++)
            chk("final ram", ram[w], mword(w));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
